// File: rtl/rr_onehot_mux_if.sv
// Handshake bundle for rr_onehot_mux: producer requests/data in, one-hot grant and
// registered output beat out. The slave modport is the mux side.
interface rr_onehot_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4
);
  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH*DATA_W-1:0] data_i;
  logic [NUM_CH-1:0]        gnt_o;
  logic                     valid_o;
  logic                     ready_i;
  logic [DATA_W-1:0]        data_o;
  logic [NUM_CH-1:0]        sel_o;

  modport master (
    output req_i, data_i, ready_i,
    input  gnt_o, valid_o, data_o, sel_o
  );

  modport slave (
    input  req_i, data_i, ready_i,
    output gnt_o, valid_o, data_o, sel_o
  );
endinterface

// File: rtl/rr_onehot_mux.sv
// N-channel registered one-hot mux with internal arbitration and valid/ready output stage.
// Define RR_ARB_EN for round-robin arbitration; otherwise lowest-index fixed priority.
module rr_onehot_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  rr_onehot_mux_if.slave bus
);

  logic              load;
  logic [NUM_CH-1:0] win;
  logic [NUM_CH-1:0] gnt;
  logic [DATA_W-1:0] mux;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [NUM_CH-1:0] sel;

  assign load = !valid || bus.ready_i;

`ifdef RR_ARB_EN
  localparam int PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Circular scan starting one past the last winner; wrap is explicit so
  // non-power-of-2 channel counts never index past NUM_CH-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = last_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (idx == PTR_W'(NUM_CH - 1)) ? '0 : idx + PTR_W'(1);
      if (!found && bus.req_i[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) gnt_idx = gnt_idx | PTR_W'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ptr <= PTR_W'(NUM_CH - 1);
    end else if (|gnt) begin
      last_ptr <= gnt_idx;
    end
  end
`else
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && bus.req_i[k]) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

  // Reset gates the grant so no producer sees an accept while state is cleared.
  assign gnt = (reset && load) ? win : '0;

  always_comb begin
    mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mux = mux | (bus.data_i[k*DATA_W +: DATA_W] & {DATA_W{gnt[k]}});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      sel   <= '0;
    end else if (|gnt) begin
      valid <= 1'b1;
      data  <= mux;
      sel   <= gnt;
    end else if (load) begin
      valid <= 1'b0;
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.valid_o = valid;
  assign bus.data_o  = data;
  assign bus.sel_o   = sel;

endmodule

// File: tb/tb_rr_onehot_mux.sv
// Self-checking bench for rr_onehot_mux: directed scenarios plus a randomized run
// against a behavioural arbitration model and a beat scoreboard.
module tb_rr_onehot_mux;
  localparam int N = 4;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  rr_onehot_mux_if #(.NUM_CH(N), .DATA_W(W)) bus ();

  rr_onehot_mux #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [N-1:0] m_sel;
  int           m_last;

  typedef struct {
    logic [N-1:0] sel;
    logic [W-1:0] data;
  } beat_t;
  beat_t sb[$];

  function automatic int idx_of(input logic [N-1:0] oh);
    int r;
    r = 0;
    for (int k = 0; k < N; k++) if (oh[k]) r = k;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    int k;
    g = '0;
    if (!reset || (m_valid && !bus.ready_i) || bus.req_i == '0) return g;
`ifdef RR_ARB_EN
    for (int i = 1; i <= N; i++) begin
      k = (m_last + i) % N;
      if (bus.req_i[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      k = i;
      if (bus.req_i[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
`endif
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;
    m_last  = N - 1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rd);
    @(negedge clk);
    bus.req_i   = r;
    bus.data_i  = d;
    bus.ready_i = rd;
    #1;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    logic [N-1:0] g;
    int k;
    g = exp_gnt();
    if (g != '0) begin
      k       = idx_of(g);
      m_data  = bus.data_i[k*W +: W];
      m_sel   = g;
      m_valid = 1'b1;
      m_last  = k;
    end else if (!m_valid || bus.ready_i) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_i   = N'($urandom);
      bus.data_i  = (N*W)'($urandom);
      bus.ready_i = 1'($urandom);
      #1;
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.valid_o); end
      checks++; if (bus.data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
      checks++; if (bus.sel_o !== '0) begin errors++; $display("FAIL reset_sel: got %b want 0000", bus.sel_o); end
      checks++; if (bus.gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt_o); end
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    drive(4'b0100, 16'h0A00, 1'b1);
    checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", bus.gnt_o); end
    tick();
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", bus.valid_o); end
    checks++; if (bus.data_o !== 4'hA) begin errors++; $display("FAIL single_data: got %h want a", bus.data_o); end
    checks++; if (bus.sel_o !== 4'b0100) begin errors++; $display("FAIL single_sel: got %b want 0100", bus.sel_o); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [5];
`ifdef RR_ARB_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 16'h4321, 1'b1);
      checks++; if (bus.gnt_o !== exp_seq[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp_seq[i]); end
      tick();
      checks++; if (bus.sel_o !== exp_seq[i]) begin errors++; $display("FAIL rr_sel[%0d]: got %b want %b", i, bus.sel_o, exp_seq[i]); end
      checks++; if (bus.data_o !== W'(idx_of(exp_seq[i]) + 1)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, bus.data_o, idx_of(exp_seq[i]) + 1); end
    end
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] exp_next;
    logic [W-1:0] exp_data;
`ifdef RR_ARB_EN
    exp_next = 4'b0010;
    exp_data = 4'h8;
`else
    exp_next = 4'b0001;
    exp_data = 4'h7;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 16'h0087, 1'b0);
      checks++; if (bus.gnt_o !== '0) begin errors++; $display("FAIL bp_gnt[%0d]: got %b want 0000", i, bus.gnt_o); end
      tick();
      checks++; if (bus.valid_o !== 1'b1 || bus.sel_o !== 4'b0001 || bus.data_o !== 4'h1) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%0b sel=%b data=%h want v=1 sel=0001 data=1", i, bus.valid_o, bus.sel_o, bus.data_o);
      end
    end
    drive(4'b0011, 16'h0087, 1'b1);
    checks++; if (bus.gnt_o !== exp_next) begin errors++; $display("FAIL bp_release_gnt: got %b want %b", bus.gnt_o, exp_next); end
    tick();
    checks++; if (bus.sel_o !== exp_next || bus.data_o !== exp_data) begin
      errors++; $display("FAIL bp_release_beat: got sel=%b data=%h want sel=%b data=%h", bus.sel_o, bus.data_o, exp_next, exp_data);
    end
  endtask

  task automatic test_bubble();
    drive('0, 16'h0087, 1'b1);
    checks++; if (bus.gnt_o !== '0) begin errors++; $display("FAIL bubble_gnt: got %b want 0000", bus.gnt_o); end
    tick();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %0b want 0", bus.valid_o); end
    checks++; if (bus.data_o !== m_data || bus.sel_o !== m_sel) begin
      errors++; $display("FAIL bubble_hold: got data=%h sel=%b want data=%h sel=%b", bus.data_o, bus.sel_o, m_data, m_sel);
    end
    drive(4'b1000, 16'h5000, 1'b1);
    checks++; if (bus.gnt_o !== 4'b1000) begin errors++; $display("FAIL bubble_new_gnt: got %b want 1000", bus.gnt_o); end
    tick();
    checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== 4'h5 || bus.sel_o !== 4'b1000) begin
      errors++; $display("FAIL bubble_new_beat: got v=%0b data=%h sel=%b want v=1 data=5 sel=1000", bus.valid_o, bus.data_o, bus.sel_o);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    logic           rd;
    logic [N-1:0]   g;
    logic [N-1:0]   g_prev;
    int             starve [N];
    beat_t          b;
    g_prev = '0;
    for (int k = 0; k < N; k++) starve[k] = 0;
    sb.delete();
    if (m_valid) sb.push_back('{sel: m_sel, data: m_data});
    for (int cyc = 0; cyc < 300; cyc++) begin
      r = bus.req_i;
      d = bus.data_i;
      for (int k = 0; k < N; k++) begin
        if (!(r[k] && !g_prev[k]) || $urandom_range(0, 19) == 0) begin
          r[k]         = 1'($urandom_range(0, 1));
          d[k*W +: W]  = W'($urandom);
        end
      end
      rd = ($urandom_range(0, 3) != 0);
      drive(r, d, rd);
      if (m_valid && rd) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_sb_empty[%0d]: got beat data=%h with no granted beat outstanding", cyc, bus.data_o);
        end else begin
          b = sb.pop_front();
          if (bus.data_o !== b.data || bus.sel_o !== b.sel) begin
            errors++; $display("FAIL rand_sb[%0d]: got data=%h sel=%b want data=%h sel=%b", cyc, bus.data_o, bus.sel_o, b.data, b.sel);
          end
        end
      end
      g = exp_gnt();
      checks++; if (!$onehot0(bus.gnt_o)) begin errors++; $display("FAIL rand_onehot[%0d]: got %b want one-hot or zero", cyc, bus.gnt_o); end
      checks++; if (bus.gnt_o !== g) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, bus.gnt_o, g); end
      if (g != '0) sb.push_back('{sel: g, data: d[idx_of(g)*W +: W]});
`ifdef RR_ARB_EN
      for (int k = 0; k < N; k++) begin
        if (!r[k] || g[k]) starve[k] = 0;
        else if (g != '0) starve[k]++;
        checks++; if (starve[k] > N - 1) begin errors++; $display("FAIL rand_starve[%0d] ch%0d: got %0d grants to others want <= %0d", cyc, k, starve[k], N - 1); end
      end
`endif
      g_prev = g;
      tick();
      checks++; if (bus.valid_o !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0b want %0b", cyc, bus.valid_o, m_valid); end
      checks++; if (bus.data_o !== m_data || bus.sel_o !== m_sel) begin
        errors++; $display("FAIL rand_out[%0d]: got data=%h sel=%b want data=%h sel=%b", cyc, bus.data_o, bus.sel_o, m_data, m_sel);
      end
    end
    checks++; if (sb.size() != (m_valid ? 1 : 0)) begin errors++; $display("FAIL rand_sb_drain: got %0d outstanding want %0d", sb.size(), m_valid ? 1 : 0); end
  endtask

  task automatic test_reset_mid();
    drive(4'b0010, 16'h00C0, 1'b1);
    tick();
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL mid_setup_valid: got %0b want 1", bus.valid_o); end
    @(negedge clk);
    bus.req_i   = 4'b1001;
    bus.ready_i = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.sel_o !== '0) begin
      errors++; $display("FAIL mid_reset_clear: got v=%0b data=%h sel=%b want all 0", bus.valid_o, bus.data_o, bus.sel_o);
    end
    checks++; if (bus.gnt_o !== '0) begin errors++; $display("FAIL mid_reset_gnt: got %b want 0000", bus.gnt_o); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_restart_gnt: got %b want 0001", bus.gnt_o); end
    tick();
    checks++; if (bus.sel_o !== 4'b0001 || bus.valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_restart_beat: got v=%0b sel=%b want v=1 sel=0001", bus.valid_o, bus.sel_o);
    end
  endtask

  initial begin
    bus.req_i   = '0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_bubble();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
